// File: rtl/ws2812_frame_scheduler.sv
// Frame-level WS2812 controller: double-buffered GRB pixel store, per-frame pixel streaming
// over valid/ready, then a latch (reset-low) request to the bit encoder.
module ws2812_frame_scheduler #(
  parameter int unsigned LED_NUM  = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned CLK_FRE  = 27_000_000,
  parameter int unsigned FRAME_HZ = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_data,
  input  logic              i_commit,
  output logic              o_commit_pending,
  output logic              o_pix_valid,
  output logic [23:0]       o_pix_data,
  input  logic              i_pix_ready,
  output logic              o_latch_req,
  input  logic              i_latch_done,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [15:0]       o_frame_cnt
);

  localparam int unsigned FRAME_TICKS = CLK_FRE / FRAME_HZ;
  localparam int unsigned TIMER_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(FRAME_TICKS - 1);
  localparam logic [ADDR_W-1:0]  IdxLast   = ADDR_W'(LED_NUM - 1);
  localparam logic [ADDR_W:0]    LedNumExt = (ADDR_W + 1)'(LED_NUM);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StLatch} state_e;

  state_e              r_state, w_state_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_bank_sel, w_bank_sel_next;
  logic                r_pending, w_pending_next;
  logic [ADDR_W-1:0]   r_idx, w_idx_next;
  logic                r_pix_valid, w_pix_valid_next;
  logic [23:0]         r_pix_data, w_pix_data_next;
  logic                r_latch_req, w_latch_req_next;
  logic                r_overrun, w_overrun_next;
  logic [15:0]         r_frame_cnt, w_frame_cnt_next;
  logic                w_tick, w_hs, w_wr_ok;

  // Sized to the full address space so any wr_addr indexes legally; out-of-range writes are gated.
  logic [23:0] r_mem [2][2**ADDR_W];

  assign w_tick  = (r_timer == TimerLast);
  assign w_hs    = r_pix_valid && i_pix_ready;
  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < LedNumExt);

  // Writes always target the back bank as seen before any same-cycle swap.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[~r_bank_sel][i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_timer <= '0;
    else          r_timer <= w_tick ? '0 : r_timer + TIMER_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_tick) w_state_next = StLoad;
      StLoad:  w_state_next = StSend;
      StSend:  if (w_hs) w_state_next = (r_idx == IdxLast) ? StLatch : StLoad;
      StLatch: if (i_latch_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_bank_sel_next  = r_bank_sel;
    w_pending_next   = r_pending;
    w_idx_next       = r_idx;
    w_pix_valid_next = r_pix_valid;
    w_pix_data_next  = r_pix_data;
    w_latch_req_next = r_latch_req;
    w_overrun_next   = r_overrun;
    w_frame_cnt_next = r_frame_cnt;
    if (i_commit) w_pending_next = 1'b1;
    if (w_tick && (r_state != StIdle)) w_overrun_next = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (w_tick) begin
          w_idx_next = '0;
          // Swap decision uses the pending flag from before any same-cycle commit.
          if (r_pending) begin
            w_bank_sel_next = ~r_bank_sel;
            w_pending_next  = 1'b0;
          end
        end
      end
      StLoad: begin
        w_pix_data_next  = r_mem[r_bank_sel][r_idx];
        w_pix_valid_next = 1'b1;
      end
      StSend: begin
        if (w_hs) begin
          w_pix_valid_next = 1'b0;
          if (r_idx == IdxLast) w_latch_req_next = 1'b1;
          else                  w_idx_next       = r_idx + ADDR_W'(1);
        end
      end
      StLatch: begin
        if (i_latch_done) begin
          w_latch_req_next = 1'b0;
          w_frame_cnt_next = r_frame_cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_sel  <= 1'b0;
      r_pending   <= 1'b0;
      r_idx       <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_latch_req <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_bank_sel  <= w_bank_sel_next;
      r_pending   <= w_pending_next;
      r_idx       <= w_idx_next;
      r_pix_valid <= w_pix_valid_next;
      r_pix_data  <= w_pix_data_next;
      r_latch_req <= w_latch_req_next;
      r_overrun   <= w_overrun_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  assign o_commit_pending = r_pending;
  assign o_pix_valid      = r_pix_valid;
  assign o_pix_data       = r_pix_data;
  assign o_latch_req      = r_latch_req;
  assign o_busy           = (r_state != StIdle);
  assign o_overrun        = r_overrun;
  assign o_frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler: 4 LEDs, 100-cycle frames, hand-written pixel vectors.
module tb_ws2812_frame_scheduler;

  localparam int unsigned LED_NUM = 4;
  localparam int unsigned ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [23:0]       wr_data = '0;
  logic              commit = 1'b0;
  logic              commit_pending;
  logic              pix_valid;
  logic [23:0]       pix_data;
  logic              pix_ready = 1'b1;
  logic              latch_req;
  logic              latch_done = 1'b0;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc;

  logic [23:0] px_a [4] = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFFFF};
  logic [23:0] px_b [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};

  ws2812_frame_scheduler #(
    .LED_NUM (LED_NUM),
    .ADDR_W  (ADDR_W),
    .CLK_FRE (3000),
    .FRAME_HZ(30)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_commit        (commit),
    .o_commit_pending(commit_pending),
    .o_pix_valid     (pix_valid),
    .o_pix_data      (pix_data),
    .i_pix_ready     (pix_ready),
    .o_latch_req     (latch_req),
    .i_latch_done    (latch_done),
    .o_busy          (busy),
    .o_overrun       (overrun),
    .o_frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  // Mirrors the frame timer phase: value equals timer between edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(n < 300), 1);
  endtask

  // Streams one frame with ready high except an optional 20-cycle stall (which also writes px_b).
  task automatic stream_frame(input string tag, input bit use_b, input int stall_idx,
                              input int latch_hold, input logic [15:0] exp_cnt,
                              input logic exp_pend);
    logic [23:0] e;
    wait_busy(tag);
    check({tag, "_phase"}, cyc % 100, 0);
    check({tag, "_load_gap"}, 32'(pix_valid), 0);
    check({tag, "_pend_start"}, 32'(commit_pending), 32'(exp_pend));
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      e = use_b ? px_b[p] : px_a[p];
      check({tag, "_valid"}, 32'(pix_valid), 1);
      check({tag, "_data"}, 32'(pix_data), 32'(e));
      if (p == stall_idx) begin
        pix_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
          if (k < 4) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(k); wr_data = px_b[k];
          end else begin
            wr_en = 1'b0;
          end
          @(negedge clk);
          check({tag, "_stall_valid"}, 32'(pix_valid), 1);
          check({tag, "_stall_data"}, 32'(pix_data), 32'(e));
        end
        wr_en = 1'b0;
        pix_ready = 1'b1;
      end
      @(negedge clk);
      if (p < 3) begin
        check({tag, "_gap"}, 32'(pix_valid), 0);
        check({tag, "_no_latch"}, 32'(latch_req), 0);
        @(negedge clk);
      end
    end
    check({tag, "_latch_req"}, 32'(latch_req), 1);
    check({tag, "_after_last"}, 32'(pix_valid), 0);
    for (int k = 0; k < latch_hold; k++) @(negedge clk);
    check({tag, "_latch_hold"}, 32'(latch_req), 1);
    check({tag, "_cnt_hold"}, 32'(frame_cnt), 32'(exp_cnt - 16'd1));
    latch_done = 1'b1;
    @(negedge clk);
    latch_done = 1'b0;
    check({tag, "_latch_clr"}, 32'(latch_req), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_pend_end"}, 32'(commit_pending), 32'(exp_pend));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_data", 32'(pix_data), 0);
    check("rst_latch", 32'(latch_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_pend", 32'(commit_pending), 0);
    rst_n = 1'b1;

    // T1: fill back bank, commit, one plain frame
    for (int k = 0; k < 4; k++) write_px(ADDR_W'(k), px_a[k]);
    write_px(3'd5, 24'hDEAD00);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check("pend_set", 32'(commit_pending), 1);
    check("pre_busy", 32'(busy), 0);
    stream_frame("f1", 1'b0, -1, 3, 16'd1, 1'b0);

    // T2/T3: stall on pixel 2 while writing the back bank; no commit
    stream_frame("f2", 1'b0, 2, 2, 16'd2, 1'b0);
    stream_frame("f3", 1'b0, -1, 1, 16'd3, 1'b0);

    // T5: commit in the tick cycle
    n = 0;
    while ((cyc % 100) != 99 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_align", 32'(n < 200), 1);
    check("t5_idle", 32'(busy), 0);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    stream_frame("f4", 1'b0, -1, 1, 16'd4, 1'b1);
    stream_frame("f5", 1'b1, -1, 1, 16'd5, 1'b0);

    // T4: hold the latch across a tick
    check("ovr_before", 32'(overrun), 0);
    stream_frame("f6", 1'b1, -1, 120, 16'd6, 1'b0);
    check("ovr_after", 32'(overrun), 1);
    repeat (5) @(negedge clk);
    check("ovr_no_frame", 32'(busy), 0);
    check("ovr_cnt", 32'(frame_cnt), 6);

    // T6: async reset in the middle of pixel 1
    wait_busy("f7");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("f7_px1", 32'(pix_data), 32'(px_b[1]));
    check("f7_px1_valid", 32'(pix_valid), 1);
    pix_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(pix_valid), 0);
    check("arst_latch", 32'(latch_req), 0);
    check("arst_cnt", 32'(frame_cnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_ready = 1'b1;
    stream_frame("f8", 1'b1, -1, 1, 16'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
